// File: rtl/core_l1i_resp.sv
// Direct-mapped read-only L1 instruction cache, responder side of the fetch interface.
// Optional L1I_STAT_EN adds hit/miss counters (l1i_hit_cnt, l1i_miss_cnt).
module core_l1i_resp #(
  parameter int LINES      = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        l1i_req_val,
  input  logic [31:0] l1i_req_addr,
  output logic        l1i_req_rdy,
  input  logic        l1i_kill,
  output logic        l1i_ack,
  output logic [31:0] l1i_rdata,
  input  logic        l1i_flush,
  output logic        mem_req_val,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_rdy,
  input  logic        mem_resp_val,
  input  logic [31:0] mem_resp_data
`ifdef L1I_STAT_EN
  ,
  output logic [31:0] l1i_hit_cnt,
  output logic [31:0] l1i_miss_cnt
`endif
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - OFF_W - IDX_W;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_REFILL_REQ,
    S_REFILL_DATA
  } state_t;

  state_t            state;
  logic [29:0]       req_pc;
  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [31:0]       data_mem [LINES*LINE_WORDS];
  logic [OFF_W-1:0]  beat_cnt;
  logic              kill_pend;
  logic              flush_pend;
  logic [31:0]       rdata_q;

  logic [OFF_W-1:0]  req_off;
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic              hit;
  logic [31:0]       rd_word;
  logic              in_refill;
  logic              last_beat;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^l1i_req_addr[1:0];

  assign req_off = req_pc[OFF_W-1:0];
  assign req_idx = req_pc[OFF_W +: IDX_W];
  assign req_tag = req_pc[29 -: TAG_W];

  assign hit     = valid[req_idx] && (tag_mem[req_idx] == req_tag);
  assign rd_word = data_mem[{req_idx, req_off}];

  // Lookup is combinational on the registered pc so hits return in the cycle after acceptance.
  assign l1i_ack     = (state == S_LOOKUP) && hit && !l1i_kill;
  assign l1i_req_rdy = (state == S_IDLE) || l1i_ack;
  assign l1i_rdata   = l1i_ack ? rd_word : rdata_q;

  assign in_refill = (state == S_REFILL_REQ) || (state == S_REFILL_DATA);
  assign last_beat = (state == S_REFILL_DATA) && mem_resp_val && (beat_cnt == LAST_BEAT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      req_pc       <= '0;
      valid        <= '0;
      beat_cnt     <= '0;
      kill_pend    <= 1'b0;
      flush_pend   <= 1'b0;
      rdata_q      <= '0;
      mem_req_val  <= 1'b0;
      mem_req_addr <= '0;
    end else begin
      if (l1i_ack) rdata_q <= rd_word;
      if (l1i_req_val && l1i_req_rdy) req_pc <= l1i_req_addr[31:2];

      case (state)
        S_IDLE: begin
          if (l1i_req_val) state <= S_LOOKUP;
        end
        S_LOOKUP: begin
          if (l1i_kill) begin
            state <= S_IDLE;
          end else if (hit) begin
            state <= l1i_req_val ? S_LOOKUP : S_IDLE;
          end else begin
            state        <= S_REFILL_REQ;
            mem_req_val  <= 1'b1;
            mem_req_addr <= {req_pc[29:OFF_W], {(OFF_W+2){1'b0}}};
          end
        end
        S_REFILL_REQ: begin
          if (mem_req_rdy) begin
            mem_req_val <= 1'b0;
            state       <= S_REFILL_DATA;
          end
        end
        S_REFILL_DATA: begin
          if (mem_resp_val) begin
            beat_cnt <= beat_cnt + OFF_W'(1);
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt       <= '0;
              valid[req_idx] <= 1'b1;
              state          <= (kill_pend || l1i_kill) ? S_IDLE : S_LOOKUP;
            end
          end
        end
        default: state <= S_IDLE;
      endcase

      // Kill and flush are deferred across a refill; the line is always installed first.
      if (in_refill) begin
        kill_pend <= (kill_pend || l1i_kill) && !last_beat;
        if (l1i_flush) flush_pend <= 1'b1;
      end else if (l1i_flush || flush_pend) begin
        valid      <= '0;
        flush_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if ((state == S_REFILL_DATA) && mem_resp_val) begin
      data_mem[{req_idx, beat_cnt}] <= mem_resp_data;
      if (beat_cnt == LAST_BEAT) tag_mem[req_idx] <= req_tag;
    end
  end

`ifdef L1I_STAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l1i_hit_cnt  <= '0;
      l1i_miss_cnt <= '0;
    end else if (state == S_LOOKUP) begin
      if (hit) l1i_hit_cnt  <= l1i_hit_cnt + 32'd1;
      else     l1i_miss_cnt <= l1i_miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_core_l1i_resp.sv
// Bench for core_l1i_resp: directed vector table, hand sequences and random transactions
// checked against a line-level cache model (LINES=16, LINE_WORDS=4).
module tb_core_l1i_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_val;
  logic [31:0] req_addr;
  logic        rdy;
  logic        kill;
  logic        ack;
  logic [31:0] rdata;
  logic        flush;
  logic        mem_req_val;
  logic [31:0] mem_req_addr;
  logic        mem_req_rdy;
  logic        mem_resp_val;
  logic [31:0] mem_resp_data;
`ifdef L1I_STAT_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  always #5 clk = ~clk;

  core_l1i_resp #(.LINES(16), .LINE_WORDS(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .l1i_req_val   (req_val),
    .l1i_req_addr  (req_addr),
    .l1i_req_rdy   (rdy),
    .l1i_kill      (kill),
    .l1i_ack       (ack),
    .l1i_rdata     (rdata),
    .l1i_flush     (flush),
    .mem_req_val   (mem_req_val),
    .mem_req_addr  (mem_req_addr),
    .mem_req_rdy   (mem_req_rdy),
    .mem_resp_val  (mem_resp_val),
    .mem_resp_data (mem_resp_data)
`ifdef L1I_STAT_EN
    ,
    .l1i_hit_cnt   (hit_cnt),
    .l1i_miss_cnt  (miss_cnt)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    bit          exp_hit;
    bit          flush_acc;
    bit          kill_acc;
    bit          kill_lk;
    bit          flush_lk;
    int          kill_beat;
    int          flush_beat;
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] last_rdata;
  bit          mvalid [16];
  logic [23:0] mtag   [16];
  vec_t        vecs   [18];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Backing memory contents; line 0x100 holds 0xA0..0xA3.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w[31:4] == 28'h0000010) return 32'hA0 + {30'd0, w[3:2]};
    return w ^ 32'h5EED_0000;
  endfunction

  function automatic vec_t mk(input logic [31:0] a, input bit h);
    vec_t v;
    v = '{a, h, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1};
    return v;
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return mvalid[a[7:4]] && (mtag[a[7:4]] == a[31:8]);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One fetch from an idle cache: accept, lookup, optional refill and replay.
  task automatic do_req(input vec_t v);
    logic [31:0] line;
    logic [31:0] word;
    bit          exp_ack;
    bit          killed;
    int          d;
    int          g;
    line = {v.addr[31:4], 4'h0};
    word = mem_word(v.addr);
    if (v.flush_acc) model_clear();
    req_val = 1'b1; req_addr = v.addr; kill = v.kill_acc; flush = v.flush_acc;
    #1;
    chk("accept_rdy", rdy, 1);
    tick();
    req_val = 1'b0; req_addr = $urandom(); kill = v.kill_lk; flush = v.flush_lk;
    #1;
    exp_ack = v.exp_hit && !v.kill_lk;
    chk("lookup_ack", ack, exp_ack);
    chk("lookup_rdy", rdy, exp_ack);
    if (exp_ack) begin
      chk("lookup_rdata", rdata, word);
      last_rdata = word;
    end else begin
      chk("hold_rdata", rdata, last_rdata);
    end
    if (v.flush_lk) model_clear();
    tick();
    kill = 1'b0; flush = 1'b0;
    #1;
    if (v.kill_lk || v.exp_hit) begin
      chk("no_refill", mem_req_val, 0);
      return;
    end
    chk("refill_val", mem_req_val, 1);
    chk("refill_addr", mem_req_addr, line);
    chk("refill_rdy", rdy, 0);
    d = $urandom_range(0, 3);
    repeat (d) begin
      tick(); #1;
      chk("refill_hold", mem_req_val, 1);
    end
    mem_req_rdy = 1'b1;
    tick();
    mem_req_rdy = 1'b0;
    #1;
    chk("refill_req_drop", mem_req_val, 0);
    for (int b = 0; b < 4; b++) begin
      g = $urandom_range(0, 2);
      repeat (g) begin
        mem_resp_val = 1'b0; mem_resp_data = $urandom();
        tick(); #1;
        chk("refill_no_ack", ack, 0);
      end
      mem_resp_val = 1'b1; mem_resp_data = mem_word(line + 32'(4 * b));
      kill = (b == v.kill_beat); flush = (b == v.flush_beat);
      tick();
      mem_resp_val = 1'b0; kill = 1'b0; flush = 1'b0;
      #1;
    end
    killed = (v.kill_beat >= 0) && (v.kill_beat < 4);
    chk("replay_ack", ack, !killed);
    chk("replay_rdy", rdy, 1);
    if (!killed) begin
      chk("replay_rdata", rdata, word);
      last_rdata = word;
    end else begin
      chk("killed_hold_rdata", rdata, last_rdata);
    end
    mvalid[v.addr[7:4]] = 1'b1;
    mtag[v.addr[7:4]]   = v.addr[31:8];
    tick();
    if ((v.flush_beat >= 0) && (v.flush_beat < 4)) model_clear();
    #1;
  endtask

  task automatic back_to_back();
    logic [31:0] a [3];
    a[0] = 32'h100; a[1] = 32'h108; a[2] = 32'h10C;
    req_val = 1'b1; req_addr = a[0];
    #1;
    chk("b2b_rdy0", rdy, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i < 2) req_addr = a[i+1];
      else       req_val = 1'b0;
      #1;
      chk("b2b_ack", ack, 1);
      chk("b2b_rdata", rdata, mem_word(a[i]));
      chk("b2b_rdy", rdy, 1);
    end
    last_rdata = mem_word(a[2]);
    tick();
    #1;
  endtask

  task automatic reset_mid_refill();
    req_val = 1'b1; req_addr = 32'h404;
    #1;
    tick();
    req_val = 1'b0;
    tick();
    #1;
    chk("rst_pre_req", mem_req_val, 1);
    mem_req_rdy = 1'b1;
    tick();
    mem_req_rdy = 1'b0; mem_resp_val = 1'b1; mem_resp_data = mem_word(32'h400);
    tick();
    #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_ack", ack, 0);
    chk("rst_mid_memval", mem_req_val, 0);
    chk("rst_mid_memaddr", mem_req_addr, 0);
    chk("rst_mid_rdy", rdy, 1);
    chk("rst_mid_rdata", rdata, 0);
    last_rdata = '0;
    model_clear();
    mem_resp_data = 32'hDEAD_BEEF;
    tick();
    rst = 1'b0;
    tick(); tick();
    #1;
    chk("rst_stray_beats_ack", ack, 0);
    chk("rst_stray_beats_memval", mem_req_val, 0);
    mem_resp_val = 1'b0;
    tick();
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_val = 1'b0; req_addr = '0; kill = 1'b0; flush = 1'b0;
    mem_req_rdy = 1'b0; mem_resp_val = 1'b0; mem_resp_data = '0;
    last_rdata = '0;
    model_clear();

    vecs[0]  = mk(32'h0000_0104, 1'b0);
    vecs[1]  = mk(32'h0000_0144, 1'b0);
    vecs[2]  = mk(32'h0000_0204, 1'b0);
    vecs[3]  = mk(32'h0000_0104, 1'b0);
    vecs[4]  = mk(32'h0000_010C, 1'b1);
    vecs[5]  = mk(32'h0000_0104, 1'b0); vecs[5].flush_acc = 1'b1; vecs[5].kill_beat = 1;
    vecs[6]  = mk(32'h0000_0100, 1'b1);
    vecs[7]  = mk(32'h0000_0300, 1'b0); vecs[7].flush_beat = 2;
    vecs[8]  = mk(32'h0000_0300, 1'b0);
    vecs[9]  = mk(32'h0000_0100, 1'b0);
    vecs[10] = mk(32'h0000_0100, 1'b1); vecs[10].kill_lk = 1'b1;
    vecs[11] = mk(32'h0000_0108, 1'b1); vecs[11].kill_acc = 1'b1;
    vecs[12] = mk(32'h0000_010C, 1'b1); vecs[12].flush_lk = 1'b1;
    vecs[13] = mk(32'h0000_010C, 1'b0);
    vecs[14] = mk(32'h7FFF_FFF0, 1'b0); vecs[14].kill_beat = 3;
    vecs[15] = mk(32'h7FFF_FFFC, 1'b1);
    vecs[16] = mk(32'h0000_0500, 1'b0); vecs[16].kill_lk = 1'b1;
    vecs[17] = mk(32'h0000_0507, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_ack", ack, 0);
    chk("reset_rdy", rdy, 1);
    chk("reset_memval", mem_req_val, 0);
    chk("reset_memaddr", mem_req_addr, 0);
    chk("reset_rdata", rdata, 0);
`ifdef L1I_STAT_EN
    chk("reset_hit_cnt", hit_cnt, 0);
    chk("reset_miss_cnt", miss_cnt, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    tick();

    do_req(vecs[0]);
    back_to_back();
    for (int i = 1; i < 18; i++) do_req(vecs[i]);
    do_req(mk(32'h0000_0503, 1'b1));

    reset_mid_refill();
    do_req(mk(32'h0000_0104, 1'b0));
    do_req(mk(32'h0000_0214, 1'b0));
    do_req(mk(32'h0000_0100, 1'b1));
    do_req(mk(32'h0000_0108, 1'b1));
    do_req(mk(32'h0000_0210, 1'b1));
`ifdef L1I_STAT_EN
    chk("stat_hit_cnt", hit_cnt, 5);
    chk("stat_miss_cnt", miss_cnt, 2);
`endif

    for (int n = 0; n < 150; n++) begin
      vec_t v;
      logic [23:0] t;
      t = 24'($urandom_range(0, 2));
      v = mk({t, 4'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))}, 1'b0);
      v.flush_acc  = ($urandom_range(0, 9) == 0);
      v.kill_acc   = ($urandom_range(0, 9) == 0);
      v.kill_lk    = ($urandom_range(0, 9) == 0);
      v.flush_lk   = ($urandom_range(0, 9) == 0);
      v.kill_beat  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
      v.flush_beat = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
      v.exp_hit    = !v.flush_acc && model_hit(v.addr);
      do_req(v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
